// File: rtl/wb_master_pkg.sv
// Shared constants, state encoding and cycle-type helpers for the Wishbone
// burst master and its timer.
package wb_master_pkg;

    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_INCR    = 3'b010;
    localparam logic [2:0] CTI_EOB     = 3'b111;
    localparam logic [1:0] BTE_LINEAR  = 2'b00;

    localparam logic [1:0] ERR_OK      = 2'd0;
    localparam logic [1:0] ERR_BUS     = 2'd1;
    localparam logic [1:0] ERR_RETRY   = 2'd2;
    localparam logic [1:0] ERR_TIMEOUT = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_XFER       = 2'd1,
        ST_RETRY_WAIT = 2'd2,
        ST_FINISH     = 2'd3
    } state_e;

    // Cycle type for a first issue of a beat.
    function automatic logic [2:0] beat_cti(input logic is_burst, input logic is_last);
        if (!is_burst)
            return CTI_CLASSIC;
        return is_last ? CTI_EOB : CTI_INCR;
    endfunction

    // A re-issued beat never signals end-of-burst; the last one goes out classic.
    function automatic logic [2:0] retry_cti(input logic is_last);
        return is_last ? CTI_CLASSIC : CTI_INCR;
    endfunction

endpackage

// File: rtl/wb_master_timer.sv
// Loadable saturating down-counter; shared between the ack timeout and the
// retry back-off gap.
module wb_master_timer #(
    parameter int W = 9
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         en_i,
    output logic         expired_o
);

    logic [W-1:0] cnt_q;

    always_ff @(posedge clk_i) begin
        if (!rst_ni)
            cnt_q <= '0;
        else if (load_i)
            cnt_q <= load_val_i;
        else if (en_i && (cnt_q != '0))
            cnt_q <= cnt_q - 1'b1;
    end

    assign expired_o = (cnt_q == '0);

endmodule

// File: rtl/wb_burst_master.sv
// Wishbone B3 classic / incrementing-burst master with a write data stream,
// per-beat read pulses, retry back-off, ack timeout and an abort code.
module wb_burst_master
    import wb_master_pkg::*;
#(
    parameter int DW        = 32,
    parameter int AW        = 32,
    parameter int MAX_BURST = 16,
    parameter int TIMEOUT   = 256,
    parameter int MAX_RETRY = 3,
    parameter int RETRY_GAP = 4,
    localparam int SW  = DW / 8,
    localparam int BLW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1,
    localparam int RCW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1,
    localparam int TW  = $clog2(((TIMEOUT > RETRY_GAP) ? TIMEOUT : RETRY_GAP) + 1)
) (
    input  logic           wb_clk,
    input  logic           wb_rst_n,
    output logic [AW-1:0]  wb_adr_o,
    output logic [DW-1:0]  wb_dat_o,
    output logic [SW-1:0]  wb_sel_o,
    output logic           wb_we_o,
    output logic           wb_cyc_o,
    output logic           wb_stb_o,
    output logic [2:0]     wb_cti_o,
    output logic [1:0]     wb_bte_o,
    input  logic [DW-1:0]  wb_dat_i,
    input  logic           wb_ack_i,
    input  logic           wb_err_i,
    input  logic           wb_rty_i,
    input  logic           start,
    input  logic [AW-1:0]  address,
    input  logic [SW-1:0]  selection,
    input  logic           write,
    input  logic [BLW-1:0] burst_len,
    input  logic [DW-1:0]  wr_data,
    input  logic           wr_valid,
    output logic           wr_ready,
    output logic [DW-1:0]  rd_data,
    output logic           rd_valid,
    output logic           busy,
    output logic           done,
    output logic           error,
    output logic [1:0]     err_code
);

    state_e         state_q;
    logic [AW-1:0]  adr_q;
    logic [DW-1:0]  dat_q;
    logic [SW-1:0]  sel_q;
    logic           we_q, cyc_q, stb_q;
    logic [2:0]     cti_q;
    logic [BLW-1:0] len_q, beat_q;
    logic [RCW-1:0] rty_cnt_q;
    logic           loaded_q;
    logic [DW-1:0]  rd_data_q;
    logic           rd_valid_q, done_q, error_q;
    logic [1:0]     err_code_q;

    logic           last_beat, next_last, is_burst, rty_exhausted;
    logic           abort_d;
    logic [1:0]     abort_code_d;
    logic           tmr_load_d, tmr_en_d, tmr_expired;
    logic [TW-1:0]  tmr_val_d;

    assign last_beat     = (beat_q == len_q);
    assign next_last     = ((beat_q + 1'b1) == len_q);
    assign is_burst      = (len_q != '0);
    assign rty_exhausted = (rty_cnt_q == RCW'(MAX_RETRY));
    assign wr_ready      = (state_q == ST_XFER) && we_q && !loaded_q;

    // Abort decode; err outranks rty, and any response pre-empts the timeout.
    always_comb begin
        abort_d      = 1'b0;
        abort_code_d = ERR_OK;
        if ((state_q == ST_XFER) && stb_q) begin
            if (wb_err_i) begin
                abort_d      = 1'b1;
                abort_code_d = ERR_BUS;
            end else if (wb_rty_i && rty_exhausted) begin
                abort_d      = 1'b1;
                abort_code_d = ERR_RETRY;
            end else if (!wb_rty_i && !wb_ack_i && tmr_expired) begin
                abort_d      = 1'b1;
                abort_code_d = ERR_TIMEOUT;
            end
        end
    end

    // The timer holds TIMEOUT-1 whenever stb is low so it is primed the cycle
    // stb rises; a retry reloads it with the back-off gap instead.
    always_comb begin
        tmr_load_d = 1'b1;
        tmr_en_d   = 1'b0;
        tmr_val_d  = TW'(TIMEOUT - 1);
        case (state_q)
            ST_XFER: begin
                if (stb_q) begin
                    if (wb_err_i || wb_rty_i || wb_ack_i) begin
                        if (!wb_err_i && wb_rty_i)
                            tmr_val_d = TW'(RETRY_GAP - 1);
                    end else begin
                        tmr_load_d = 1'b0;
                        tmr_en_d   = 1'b1;
                    end
                end
            end
            ST_RETRY_WAIT: begin
                if (!tmr_expired) begin
                    tmr_load_d = 1'b0;
                    tmr_en_d   = 1'b1;
                end
            end
            default: ;
        endcase
    end

    wb_master_timer #(.W(TW)) u_timer (
        .clk_i      (wb_clk),
        .rst_ni     (wb_rst_n),
        .load_i     (tmr_load_d),
        .load_val_i (tmr_val_d),
        .en_i       (tmr_en_d),
        .expired_o  (tmr_expired)
    );

    always_ff @(posedge wb_clk) begin
        if (!wb_rst_n) begin
            state_q    <= ST_IDLE;
            adr_q      <= '0;
            dat_q      <= '0;
            sel_q      <= '0;
            we_q       <= 1'b0;
            cyc_q      <= 1'b0;
            stb_q      <= 1'b0;
            cti_q      <= CTI_CLASSIC;
            len_q      <= '0;
            beat_q     <= '0;
            rty_cnt_q  <= '0;
            loaded_q   <= 1'b0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
            err_code_q <= ERR_OK;
        end else begin
            rd_valid_q <= 1'b0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        adr_q      <= address;
                        sel_q      <= selection;
                        we_q       <= write;
                        len_q      <= burst_len;
                        beat_q     <= '0;
                        rty_cnt_q  <= '0;
                        loaded_q   <= 1'b0;
                        cyc_q      <= 1'b1;
                        stb_q      <= !write;
                        cti_q      <= beat_cti(burst_len != '0, burst_len == '0);
                        err_code_q <= ERR_OK;
                        state_q    <= ST_XFER;
                    end
                end
                ST_XFER: begin
                    if (wr_ready && wr_valid) begin
                        dat_q    <= wr_data;
                        loaded_q <= 1'b1;
                        stb_q    <= 1'b1;
                    end
                    if (abort_d) begin
                        cyc_q      <= 1'b0;
                        stb_q      <= 1'b0;
                        done_q     <= 1'b1;
                        error_q    <= 1'b1;
                        err_code_q <= abort_code_d;
                        state_q    <= ST_FINISH;
                    end else if (stb_q && wb_rty_i) begin
                        cyc_q     <= 1'b0;
                        stb_q     <= 1'b0;
                        rty_cnt_q <= rty_cnt_q + 1'b1;
                        state_q   <= ST_RETRY_WAIT;
                    end else if (stb_q && wb_ack_i) begin
                        if (!we_q) begin
                            rd_data_q  <= wb_dat_i;
                            rd_valid_q <= 1'b1;
                        end
                        rty_cnt_q <= '0;
                        loaded_q  <= 1'b0;
                        if (last_beat) begin
                            cyc_q   <= 1'b0;
                            stb_q   <= 1'b0;
                            done_q  <= 1'b1;
                            state_q <= ST_FINISH;
                        end else begin
                            adr_q  <= adr_q + AW'(SW);
                            beat_q <= beat_q + 1'b1;
                            cti_q  <= beat_cti(is_burst, next_last);
                            stb_q  <= !we_q;
                        end
                    end
                end
                ST_RETRY_WAIT: begin
                    // Write data is still held from the first attempt.
                    if (tmr_expired) begin
                        cyc_q   <= 1'b1;
                        stb_q   <= 1'b1;
                        cti_q   <= retry_cti(last_beat);
                        state_q <= ST_XFER;
                    end
                end
                ST_FINISH: state_q <= ST_IDLE;
                default:   state_q <= ST_IDLE;
            endcase
        end
    end

    assign wb_adr_o = adr_q;
    assign wb_dat_o = dat_q;
    assign wb_sel_o = sel_q;
    assign wb_we_o  = we_q;
    assign wb_cyc_o = cyc_q;
    assign wb_stb_o = stb_q;
    assign wb_cti_o = cti_q;
    assign wb_bte_o = BTE_LINEAR;
    assign rd_data  = rd_data_q;
    assign rd_valid = rd_valid_q;
    assign busy     = (state_q != ST_IDLE);
    assign done     = done_q;
    assign error    = error_q;
    assign err_code = err_code_q;

endmodule

// File: tb/tb_wb_burst_master.sv
// Randomized bench for wb_burst_master: a scripted Wishbone slave plus a
// per-command outcome model derived from the retry/timeout/error rules.
module tb_wb_burst_master;

    localparam int DW = 32, AW = 32, MAX_BURST = 16;
    localparam int TIMEOUT = 256, MAX_RETRY = 3, RETRY_GAP = 4;
    localparam int R_ACK = 0, R_RTY = 1, R_ERR = 2, R_NONE = 3;
    localparam int NATT = 6;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [AW-1:0] wb_adr_o;
    logic [DW-1:0] wb_dat_o;
    logic [3:0]    wb_sel_o;
    logic          wb_we_o, wb_cyc_o, wb_stb_o;
    logic [2:0]    wb_cti_o;
    logic [1:0]    wb_bte_o;
    logic [DW-1:0] wb_dat_i = '0;
    logic          wb_ack_i = 1'b0, wb_err_i = 1'b0, wb_rty_i = 1'b0;
    logic          start = 1'b0;
    logic [AW-1:0] address = '0;
    logic [3:0]    selection = '0;
    logic          write = 1'b0;
    logic [3:0]    burst_len = '0;
    logic [DW-1:0] wr_data = '0;
    logic          wr_valid = 1'b0;
    logic          wr_ready;
    logic [DW-1:0] rd_data;
    logic          rd_valid, busy, done, error;
    logic [1:0]    err_code;

    wb_burst_master #(
        .DW(DW), .AW(AW), .MAX_BURST(MAX_BURST), .TIMEOUT(TIMEOUT),
        .MAX_RETRY(MAX_RETRY), .RETRY_GAP(RETRY_GAP)
    ) dut (
        .wb_clk(clk), .wb_rst_n(rst_n),
        .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_sel_o(wb_sel_o),
        .wb_we_o(wb_we_o), .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o),
        .wb_cti_o(wb_cti_o), .wb_bte_o(wb_bte_o),
        .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i), .wb_rty_i(wb_rty_i),
        .start(start), .address(address), .selection(selection), .write(write),
        .burst_len(burst_len), .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .rd_data(rd_data), .rd_valid(rd_valid), .busy(busy), .done(done),
        .error(error), .err_code(err_code)
    );

    always #5 clk = ~clk;

    int checks = 0, errors = 0;
    int pw[16][NATT];            // wait states before each attempt's response
    int pr[16][NATT];            // response kind per beat attempt
    logic [31:0] wdata[16];
    logic [31:0] fix_rd = '0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_quiet(input string p);
        chk({p, "_cyc"}, wb_cyc_o, 0);
        chk({p, "_stb"}, wb_stb_o, 0);
        chk({p, "_adr"}, wb_adr_o, 0);
        chk({p, "_dat"}, wb_dat_o, 0);
        chk({p, "_sel"}, wb_sel_o, 0);
        chk({p, "_we"}, wb_we_o, 0);
        chk({p, "_cti"}, wb_cti_o, 0);
        chk({p, "_bte"}, wb_bte_o, 0);
        chk({p, "_wr_ready"}, wr_ready, 0);
        chk({p, "_rd_valid"}, rd_valid, 0);
        chk({p, "_rd_data"}, rd_data, 0);
        chk({p, "_busy"}, busy, 0);
        chk({p, "_done"}, done, 0);
        chk({p, "_error"}, error, 0);
        chk({p, "_err_code"}, err_code, 0);
    endtask

    task automatic clear_plan();
        for (int b = 0; b < 16; b++) begin
            wdata[b] = $urandom;
            for (int k = 0; k < NATT; k++) begin
                pw[b][k] = 0;
                pr[b][k] = R_ACK;
            end
        end
    endtask

    task automatic rand_plan();
        int r, nr;
        clear_plan();
        for (int b = 0; b < 16; b++) begin
            for (int k = 0; k < NATT; k++)
                pw[b][k] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
            r  = int'($urandom_range(0, 999));
            nr = (r < 800) ? 0 : (r < 980) ? int'($urandom_range(1, MAX_RETRY)) : MAX_RETRY + 1;
            for (int k = 0; k < nr; k++) pr[b][k] = R_RTY;
            if (nr <= MAX_RETRY) begin
                r = int'($urandom_range(0, 999));
                if (r < 20)      pr[b][nr] = R_ERR;
                else if (r < 25) pr[b][nr] = R_NONE;
            end
        end
    endtask

    task automatic run_cmd(input bit w, input logic [31:0] a, input logic [3:0] s, input int len);
        int beat, att, waitc, wptr, gapc, stb_run, acked, exp_code, exp_acked, rc;
        bit in_gap, fin, exp_done, stop;
        logic [31:0] exp_adr;
        logic [2:0]  exp_cti;
        logic [31:0] rdq[$];

        // Outcome model: walk the response script beat by beat.
        exp_code = 0; exp_acked = 0; stop = 0;
        for (int b = 0; b <= len && !stop; b++) begin
            rc = 0;
            for (int k = 0; k < NATT; k++) begin
                if (pr[b][k] == R_ACK) begin exp_acked++; break; end
                else if (pr[b][k] == R_RTY) begin
                    rc++;
                    if (rc > MAX_RETRY) begin exp_code = 2; stop = 1; break; end
                end
                else if (pr[b][k] == R_ERR) begin exp_code = 1; stop = 1; break; end
                else begin exp_code = 3; stop = 1; break; end
            end
        end

        start = 1; address = a; selection = s; write = w; burst_len = 4'(len);
        @(posedge clk); #1;
        beat = 0; att = 0; waitc = 0; wptr = 0; gapc = 0; stb_run = 0; acked = 0;
        in_gap = 0; fin = 0; exp_done = 0;
        for (int n = 0; n < 3000 && !fin; n++) begin
            wb_ack_i = 0; wb_err_i = 0; wb_rty_i = 0; wb_dat_i = $urandom;
            // Command inputs churn while busy; the master must ignore them.
            start = ($urandom_range(0, 7) == 0); address = $urandom;
            selection = 4'($urandom); write = 1'($urandom); burst_len = 4'($urandom);
            if (rd_valid) begin
                if (rdq.size() == 0) chk("rd_extra", rd_valid, 0);
                else chk("rd_data", rd_data, rdq.pop_front());
            end
            if (exp_done || done) begin
                chk("done", done, exp_done);
                chk("err_code", err_code, exp_code);
                chk("error", error, (exp_code != 0));
                chk("cyc_end", wb_cyc_o, 0);
                chk("stb_end", wb_stb_o, 0);
                chk("busy_fin", busy, 1);
                chk("beats_acked", acked, exp_acked);
                chk("rd_left", rdq.size(), 0);
                fin = 1;
            end else if (in_gap && !wb_cyc_o) begin
                gapc++;
                chk("gap_stb", wb_stb_o, 0);
                chk("gap_wr_ready", wr_ready, 0);
            end else begin
                if (in_gap) begin chk("gap_len", gapc, RETRY_GAP); in_gap = 0; end
                chk("cyc", wb_cyc_o, 1);
                chk("busy", busy, 1);
                if (!w) chk("rd_stb", wb_stb_o, 1);
                if (wb_stb_o) begin
                    exp_adr = a + 32'(beat * 4);
                    if (att == 0) exp_cti = (len == 0) ? 3'b000 : (beat == len) ? 3'b111 : 3'b010;
                    else          exp_cti = (beat == len) ? 3'b000 : 3'b010;
                    chk("adr", wb_adr_o, exp_adr);
                    chk("cti", wb_cti_o, exp_cti);
                    chk("we", wb_we_o, w);
                    chk("sel", wb_sel_o, s);
                    if (w) begin
                        chk("wdat", wb_dat_o, wdata[beat]);
                        chk("wr_ready_stb", wr_ready, 0);
                    end
                    if (waitc < pw[beat][att]) begin
                        waitc++; stb_run++;
                    end else begin
                        waitc = 0;
                        case (pr[beat][att])
                            R_ACK: begin
                                wb_ack_i = 1;
                                if (!w) begin
                                    if (fix_rd != 0) wb_dat_i = fix_rd;
                                    rdq.push_back(wb_dat_i);
                                end
                                acked++; stb_run = 0;
                                if (beat == len) exp_done = 1;
                                beat++; att = 0;
                            end
                            R_RTY: begin
                                wb_rty_i = 1; wb_ack_i = 1'($urandom);
                                att++; stb_run = 0;
                                if (att > MAX_RETRY) exp_done = 1;
                                else begin in_gap = 1; gapc = 0; end
                            end
                            R_ERR: begin
                                wb_err_i = 1; wb_ack_i = 1; wb_rty_i = 1'($urandom);
                                exp_done = 1;
                            end
                            default: begin
                                stb_run++;
                                if (stb_run == TIMEOUT) exp_done = 1;
                            end
                        endcase
                    end
                end
            end
            if (w && !fin) begin
                wr_valid = ($urandom_range(0, 2) != 0) && (wptr <= len);
                wr_data  = wdata[wptr & 15];
                if (wr_valid && wr_ready) wptr++;
            end else begin
                wr_valid = 0;
            end
            @(posedge clk); #1;
        end
        if (!fin) chk("cmd_end", done, 1);
        start = 0; wr_valid = 0; wb_ack_i = 0; wb_err_i = 0; wb_rty_i = 0;
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog: got hang expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk_quiet("reset");
        rst_n = 1;

        // Single read, two wait states, fixed data.
        clear_plan(); pw[0][0] = 2; fix_rd = 32'hDEADBEEF;
        run_cmd(0, 32'h100, 4'hF, 0);
        fix_rd = '0;

        // Write burst of four with a bursty data stream.
        clear_plan();
        for (int i = 0; i < 4; i++) wdata[i] = 32'(i + 1);
        run_cmd(1, 32'h200, 4'hF, 3);

        // Read burst with two retries on beat 2.
        clear_plan(); pr[2][0] = R_RTY; pr[2][1] = R_RTY;
        run_cmd(0, 32'h200, 4'hF, 3);

        // Retries exhausted on a single beat.
        clear_plan();
        for (int k = 0; k <= MAX_RETRY; k++) pr[0][k] = R_RTY;
        run_cmd(0, 32'h400, 4'h3, 0);

        // Silent slave, then err together with ack.
        clear_plan(); pr[0][0] = R_NONE;
        run_cmd(0, 32'h500, 4'hF, 0);
        clear_plan(); pr[1][0] = R_ERR;
        run_cmd(1, 32'h600, 4'hC, 2);

        // Address wrap at the top of the space.
        clear_plan();
        run_cmd(0, 32'hFFFF_FFF8, 4'hF, 3);

        // Reset while beat 2 of a read burst is on the bus.
        clear_plan();
        start = 1; address = 32'h500; selection = 4'hF; write = 0; burst_len = 4'd3;
        @(posedge clk); #1;
        start = 0; wb_ack_i = 1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("pre_rst_adr", wb_adr_o, 32'h508);
        rst_n = 0; wb_ack_i = 0;
        @(posedge clk); #1;
        chk_quiet("midrst");
        rst_n = 1;
        run_cmd(0, 32'h700, 4'hF, 1);

        // Randomized commands.
        for (int i = 0; i < 40; i++) begin
            rand_plan();
            run_cmd(1'($urandom), $urandom & 32'hFFFF_FFFC, 4'($urandom_range(1, 15)),
                    ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(0, 15)));
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/wb_burst_master.md
Name: wb_burst_master

Overview:
Parametrised successor to the team's single-beat Wishbone master. It issues Wishbone B3 classic and incrementing-burst cycles of 1..MAX_BURST beats. Write data arrives on a valid/ready stream and read data leaves as per-beat pulses. Adds retry-with-backoff, an ack timeout and an error code, for DMA/test engines that sit between a local command source and the Wishbone interconnect.

Parameters:
DW, 32, data width in bits (multiple of 8)
AW, 32, address width in bits
MAX_BURST, 16, maximum beats per command (power of 2)
TIMEOUT, 256, cycles of stb without ack/err/rty before abort
MAX_RETRY, 3, rty responses tolerated per beat before abort
RETRY_GAP, 4, idle cycles with cyc low between rty and re-issue

Ports:
wb_clk  in  1  clock
wb_rst_n  in  1  synchronous active-low reset
wb_adr_o  out  AW  byte address of current beat
wb_dat_o  out  DW  write data
wb_sel_o  out  DW/8  byte selects
wb_we_o  out  1  write enable
wb_cyc_o  out  1  cycle
wb_stb_o  out  1  strobe
wb_cti_o  out  3  cycle type
wb_bte_o  out  2  burst type, always 2'b00
wb_dat_i  in  DW  read data
wb_ack_i  in  1  ack
wb_err_i  in  1  error
wb_rty_i  in  1  retry
start  in  1  command strobe, sampled in IDLE only
address  in  AW  start address, DW/8-aligned
selection  in  DW/8  byte selects, applied to every beat
write  in  1  1=write, 0=read
burst_len  in  log2(MAX_BURST)  beats minus one
wr_data  in  DW  write beat data
wr_valid  in  1  wr_data valid
wr_ready  out  1  master accepts wr_data this cycle
rd_data  out  DW  read beat data, registered
rd_valid  out  1  one-cycle pulse per read beat
busy  out  1  state != IDLE
done  out  1  one-cycle pulse at command end
error  out  1  valid with done; 1 = aborted
err_code  out  2  valid with done: 0 ok, 1 bus err, 2 retries exhausted, 3 timeout

Behaviour:
- Reset (wb_rst_n=0 at posedge): state IDLE; all Wishbone outputs 0 except wb_cti_o=0; wr_ready, rd_valid, done, error 0; rd_data 0; err_code 0; counters cleared. Reset mid-burst drops cyc/stb on the next edge with no done pulse.
- Every Wishbone output is registered.
- States: IDLE, XFER, RETRY_WAIT, FINISH.
- IDLE: start=1 latches address, selection, write, burst_len; beat counter=0; goes to XFER. A start in any other state is ignored.
- XFER read: cyc=stb=1 from the first XFER cycle.
- XFER write: stb is asserted only while a beat is loaded. wr_ready = XFER & write & !loaded. wr_valid&wr_ready loads wr_data into wb_dat_o; stb rises the next cycle. Between beats, cyc stays high and stb drops while waiting for wr_valid.
- wb_cti_o: 3'b000 if burst_len=0. Otherwise 3'b010 on all beats but the last, and 3'b111 on the last.
- Ack with stb high completes a beat. Address += DW/8 with wrap at 2^AW. Beat count increments. Retry count clears.
- On a read ack, rd_data<=wb_dat_i and rd_valid pulses the next cycle.
- Ack on the last beat: cyc/stb drop, go to FINISH.
- Response priority in the same cycle: err > rty > ack.
- err: go to FINISH with err_code=1.
- rty: drop cyc/stb, increment retry count. If the count exceeds MAX_RETRY, go to FINISH with err_code=2. Otherwise go to RETRY_WAIT.
- RETRY_WAIT: wait RETRY_GAP cycles, then re-issue the same beat (same address and data; no new wr_ready) with cti 3'b000 if it is the last beat, else 3'b010.
- Timeout counter runs while stb=1 and clears on any response. At TIMEOUT it drops cyc/stb and goes to FINISH with err_code=3.
- FINISH (1 cycle): done=1; error=(err_code!=0); then IDLE. start in FINISH is ignored.
- Latency: a single read with zero-wait ack gives stb at cycle 1, ack at cycle 1, rd_valid at cycle 2, done at cycle 2.

Decomposition:
- Package wb_master_pkg: CTI_CLASSIC/CTI_INCR/CTI_EOB constants, BTE_LINEAR, state enum encoding, err_code constants.
- One sub-module, wb_master_timer: a loadable down-counter shared by the timeout and RETRY_GAP functions, with load/enable/expired.

Test Plan:
1. Single read, addr 0x100, slave acks with 0xDEADBEEF after 2 waits -> one rd_valid with rd_data=0xDEADBEEF, cti=000, done with error=0.
2. Write burst, burst_len=3, addr 0x200, data 1..4, wr_valid gaps after beat 1 -> addresses 0x200/204/208/20C, cti 010,010,010,111, stb low during gap, cyc high throughout.
3. Read burst of 4; slave asserts rty on beat 2 twice (MAX_RETRY=3) -> beat 2 re-issued at 0x208 after 4 idle cycles each time; 4 rd_valid pulses total; error=0.
4. rty four times on one beat -> done with error=1, err_code=2, cyc low.
5. Slave never responds -> cyc/stb drop after 256 cycles; err_code=3. Next, assert ack and err together on a fresh command -> err_code=1.
6. Assert wb_rst_n=0 mid-burst at beat 2 -> next edge: all outputs at reset values, no done. A start after release begins cleanly.
